// File: rtl/nonce_tx_pkg.sv
// Shared constants, FSM state encoding and line geometry for the nonce TX framer.
// Optional build macro FRAME_CHECKSUM_EN appends a checksum trailer word to each line.
package nonce_tx_pkg;

  localparam logic [31:0] MAGIC     = 32'hA5C3_5A3C;
  localparam logic [5:0]  TX_TYPE   = 6'h2A;
  localparam logic [31:0] PAD_NONCE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    VS,
    GAP1,
    HS,
    GAP2,
    LINE,
    TRAIL
  } state_t;

  // Words on one line: header plus two nonces per word, plus the optional trailer
  function automatic int line_words(input int npl);
`ifdef FRAME_CHECKSUM_EN
    return 2 + npl / 2;
`else
    return 1 + npl / 2;
`endif
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Nonce buffer: synchronous FIFO, depth 2^AW, with a two-entry look-ahead read
// port so the framer can drain two nonces per line word.
module nonce_fifo #(
  parameter int AW = 2,
  parameter int W  = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic [1:0]    i_pop,
  output logic [W-1:0]  o_rdata0,
  output logic [W-1:0]  o_rdata1,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_ptr1;
  logic [AW:0]   r_count;
  logic          w_wr_en;

  // A push into a full FIFO still lands when a pop frees a slot the same cycle
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_wr_en   = i_push && (!o_full || (i_pop != 2'b00));
  assign w_rd_ptr1 = r_rd_ptr + 1'b1;
  assign o_rdata0  = r_mem[r_rd_ptr];
  assign o_rdata1  = r_mem[w_rd_ptr1];

  // Storage array; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; pop of 0, 1 or 2 entries per cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= r_rd_ptr + AW'(i_pop);
      r_count  <= r_count + (AW+1)'(w_wr_en) - (AW+1)'(i_pop);
    end
  end

endmodule

// File: rtl/nonce_tx_framer.sv
// Golden-nonce return path: buffers nonces and packs them into short CSI-2 TX
// frames (VSYNC, gap, HSYNC, gap, one line, trailing gap).
// Build macro FRAME_CHECKSUM_EN adds a trailer word {32'h0, XOR of real nonces}.
module nonce_tx_framer
  import nonce_tx_pkg::*;
#(
  parameter int FIFO_AW   = 2,
  parameter int NPL       = 4,
  parameter int SYNC_CYC  = 4,
  parameter int GAP_CYC   = 8,
  parameter int FLUSH_CYC = 1024
) (
  input  logic        tx_pixel_clk,
  input  logic        reset,
  input  logic        nonce_valid,
  input  logic [31:0] nonce,
  output logic        nonce_ready,
  output logic        tx_vsync,
  output logic        tx_hsync,
  output logic        tx_valid,
  output logic [63:0] tx_data,
  output logic [5:0]  tx_type,
  output logic [15:0] tx_hres,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] frame_seq
);
  localparam int LW   = line_words(NPL);
  localparam int HALF = NPL / 2;
  localparam int TW   = $clog2(FLUSH_CYC + 1);

  state_t        r_state, w_next;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_n, r_seq, w_n;
  logic          r_ovf;
  logic          r_vsync, r_hsync, r_valid;
  logic [63:0]   r_data;
  logic          w_vsync, w_hsync, w_valid, w_latch, w_seq_inc, w_go;
  logic [63:0]   w_data;
  logic [1:0]    w_pop;
  logic [31:0]   w_rdata0, w_rdata1;
  logic          w_full, w_empty;
  logic [FIFO_AW:0] w_count;
  logic [15:0]   w_slot_lo, w_slot_hi;
  logic          w_lo_real, w_hi_real;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]   r_csum, w_csum_term;
`endif

  nonce_fifo #(.AW(FIFO_AW), .W(32)) u_fifo (
    .i_clk    (tx_pixel_clk),
    .i_rst    (reset),
    .i_push   (nonce_valid),
    .i_wdata  (nonce),
    .i_pop    (w_pop),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  // Line word k carries nonce slots 2k-2 (low half) and 2k-1 (high half)
  assign w_slot_lo = {r_cnt[14:0], 1'b0} - 16'd2;
  assign w_slot_hi = w_slot_lo + 16'd1;
  assign w_lo_real = (w_slot_lo < r_n);
  assign w_hi_real = (w_slot_hi < r_n);
  assign w_go      = (int'(w_count) >= NPL) || (r_timer >= TW'(FLUSH_CYC));
  assign w_n       = (int'(w_count) >= NPL) ? 16'(NPL) : 16'(w_count);

  // Next-state, phase counter and unregistered line outputs
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt + 16'd1;
    w_vsync   = 1'b0;
    w_hsync   = 1'b0;
    w_valid   = 1'b0;
    w_data    = '0;
    w_pop     = 2'b00;
    w_latch   = 1'b0;
    w_seq_inc = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_go) begin
          w_next  = VS;
          w_latch = 1'b1;
        end
      end
      VS: begin
        w_vsync = 1'b1;
        if (r_cnt == 16'(SYNC_CYC - 1)) begin w_next = GAP1; w_cnt_nxt = '0; end
      end
      GAP1: if (r_cnt == 16'(GAP_CYC - 1)) begin w_next = HS; w_cnt_nxt = '0; end
      HS: begin
        w_hsync = 1'b1;
        if (r_cnt == 16'(SYNC_CYC - 1)) begin w_next = GAP2; w_cnt_nxt = '0; end
      end
      GAP2: if (r_cnt == 16'(GAP_CYC - 1)) begin w_next = LINE; w_cnt_nxt = '0; end
      LINE: begin
        w_valid = 1'b1;
        if (r_cnt == 16'd0) begin
          w_data = {MAGIC, r_seq, r_n};
        end else if (r_cnt <= 16'(HALF)) begin
          w_data = {w_hi_real ? w_rdata1 : PAD_NONCE, w_lo_real ? w_rdata0 : PAD_NONCE};
          // hi_real implies lo_real, so this encodes pop count 0/1/2
          w_pop  = {w_hi_real, w_lo_real & ~w_hi_real};
        end
`ifdef FRAME_CHECKSUM_EN
        else begin
          w_data = {32'h0, r_csum};
        end
`endif
        if (r_cnt == 16'(LW - 1)) begin w_next = TRAIL; w_cnt_nxt = '0; end
      end
      TRAIL: begin
        if (r_cnt == 16'(GAP_CYC - 1)) begin
          w_next    = IDLE;
          w_cnt_nxt = '0;
          w_seq_inc = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register, flush timer, latched nonce count, frame sequence and overflow flag
  always_ff @(posedge tx_pixel_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_timer <= '0;
      r_n     <= '0;
      r_seq   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_latch || (r_state != IDLE)) r_timer <= '0;
      else if (!w_empty)                r_timer <= r_timer + 1'b1;
      if (w_latch)   r_n   <= w_n;
      if (w_seq_inc) r_seq <= r_seq + 16'd1;
      if (nonce_valid && w_full && (w_pop == 2'b00)) r_ovf <= 1'b1;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  assign w_csum_term = (w_lo_real ? w_rdata0 : 32'h0) ^ (w_hi_real ? w_rdata1 : 32'h0);

  // Running XOR of the nonces drained into the current line (padding excluded)
  always_ff @(posedge tx_pixel_clk or posedge reset) begin
    if (reset)                r_csum <= '0;
    else if (w_latch)         r_csum <= '0;
    else if (w_pop != 2'b00)  r_csum <= r_csum ^ w_csum_term;
  end
`endif

  // Registered line-side outputs, cleared immediately on reset to abort a frame
  always_ff @(posedge tx_pixel_clk or posedge reset) begin
    if (reset) begin
      r_vsync <= 1'b0;
      r_hsync <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_vsync <= w_vsync;
      r_hsync <= w_hsync;
      r_valid <= w_valid;
      r_data  <= w_data;
    end
  end

  assign nonce_ready = ~w_full;
  assign tx_vsync    = r_vsync;
  assign tx_hsync    = r_hsync;
  assign tx_valid    = r_valid;
  assign tx_data     = r_data;
  assign tx_type     = TX_TYPE;
  assign tx_hres     = 16'(8 * LW);
  assign busy        = (r_state != IDLE);
  assign overflow    = r_ovf;
  assign frame_seq   = r_seq;

endmodule

// File: tb/tb_nonce_tx_framer.sv
// Self-checking bench for nonce_tx_framer (default parameters).
module tb_nonce_tx_framer;
`ifdef FRAME_CHECKSUM_EN
  localparam int          EXP_NW   = 4;
  localparam logic [15:0] EXP_HRES = 16'd32;
`else
  localparam int          EXP_NW   = 3;
  localparam logic [15:0] EXP_HRES = 16'd24;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        nonce_valid;
  logic [31:0] nonce;
  logic        nonce_ready, tx_vsync, tx_hsync, tx_valid, busy, overflow;
  logic [63:0] tx_data;
  logic [5:0]  tx_type;
  logic [15:0] tx_hres, frame_seq;

  nonce_tx_framer dut (
    .tx_pixel_clk (clk),
    .reset        (rst),
    .nonce_valid  (nonce_valid),
    .nonce        (nonce),
    .nonce_ready  (nonce_ready),
    .tx_vsync     (tx_vsync),
    .tx_hsync     (tx_hsync),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_type      (tx_type),
    .tx_hres      (tx_hres),
    .busy         (busy),
    .overflow     (overflow),
    .frame_seq    (frame_seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               npush;
    logic [5:0][31:0] nz;
    int               exp_n;
    bit               exp_ovf;
    logic [63:0]      exp_w1;
    logic [63:0]      exp_w2;
  } vec_t;

  vec_t        vecs[4];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] cap_w[8];
  int          cap_nw, cap_vs, cap_gap, cap_hs;
  bit          cap_to, cap_dirty;
  logic [15:0] exp_seq;
  bit          exp_ovf;
  logic [31:0] exp_x;
  bit          idle_to;
  int          vcount, vs_seen;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int np,
                         input logic [31:0] a, b, c, d, e, f,
                         input int en, input bit ov,
                         input logic [63:0] w1, w2);
    vecs[idx].npush   = np;
    vecs[idx].nz[0]   = a;
    vecs[idx].nz[1]   = b;
    vecs[idx].nz[2]   = c;
    vecs[idx].nz[3]   = d;
    vecs[idx].nz[4]   = e;
    vecs[idx].nz[5]   = f;
    vecs[idx].exp_n   = en;
    vecs[idx].exp_ovf = ov;
    vecs[idx].exp_w1  = w1;
    vecs[idx].exp_w2  = w2;
  endtask

  task automatic push_vec(input int idx);
    for (int k = 0; k < vecs[idx].npush; k++) begin
      @(negedge clk);
      nonce_valid = 1'b1;
      nonce       = vecs[idx].nz[k];
    end
    @(negedge clk);
    nonce_valid = 1'b0;
  endtask

  // Follows one frame: VSYNC width, gap, HSYNC width, then the valid words
  task automatic capture(input int limit);
    int phase;
    phase = 0; cap_vs = 0; cap_hs = 0; cap_gap = 0; cap_nw = 0;
    cap_to = 1'b1; cap_dirty = 1'b0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(negedge clk);
      if (!tx_valid && (tx_data != 64'h0)) cap_dirty = 1'b1;
      case (phase)
        0: if (tx_vsync) begin cap_vs = 1; phase = 1; end
        1: if (tx_vsync) cap_vs++; else begin cap_gap = 1; phase = 2; end
        2: if (tx_hsync) begin cap_hs = 1; phase = 3; end else cap_gap++;
        3: if (tx_hsync) cap_hs++; else phase = 4;
        4: if (tx_valid) begin cap_w[0] = tx_data; cap_nw = 1; phase = 5; end
        default: begin
          if (tx_valid) begin
            if (cap_nw < 8) cap_w[cap_nw] = tx_data;
            cap_nw++;
          end else begin
            cap_to = 1'b0;
            break;
          end
        end
      endcase
    end
  endtask

  task automatic wait_idle(input int limit);
    idle_to = 1'b1;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(negedge clk);
      if (!busy) begin idle_to = 1'b0; break; end
    end
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] seq, input int n,
                           input logic [63:0] w1, input logic [63:0] w2);
    chk({tag, "_timeout"}, cap_to, 1'b0);
    chk({tag, "_vs_w"}, cap_vs, 4);
    chk({tag, "_gap1"}, cap_gap, 8);
    chk({tag, "_hs_w"}, cap_hs, 4);
    chk({tag, "_nwords"}, cap_nw, EXP_NW);
    chk({tag, "_data_idle"}, cap_dirty, 1'b0);
    chk({tag, "_w0"}, cap_w[0], {32'hA5C3_5A3C, seq, 16'(n)});
    chk({tag, "_w1"}, cap_w[1], w1);
    chk({tag, "_w2"}, cap_w[2], w2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; nonce_valid = 1'b0; nonce = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", nonce_ready, 1'b1);
    chk("rst_vsync", tx_vsync, 1'b0);
    chk("rst_hsync", tx_hsync, 1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 64'h0);
    chk("rst_type", tx_type, 6'h2A);
    chk("rst_hres", tx_hres, EXP_HRES);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_seq", frame_seq, 16'h0);
    rst = 1'b0;

    set_vec(0, 4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0, 32'h0,
            4, 1'b0, 64'h2222_2222_1111_1111, 64'h4444_4444_3333_3333);
    set_vec(1, 3, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'h0, 32'h0, 32'h0,
            3, 1'b0, 64'h0B0B_0B0B_0A0A_0A0A, 64'hFFFF_FFFF_0C0C_0C0C);
    set_vec(2, 2, 32'h0F0F_0F0F, 32'hF0F0_F0F1, 32'h0, 32'h0, 32'h0, 32'h0,
            2, 1'b0, 64'hF0F0_F0F1_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF);
    set_vec(3, 6, 32'h6161_6161, 32'h6262_6262, 32'h6363_6363, 32'h6464_6464,
            32'h6565_6565, 32'h6666_6666,
            4, 1'b1, 64'h6262_6262_6161_6161, 64'h6464_6464_6363_6363);

    exp_seq = 16'h0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fork
        push_vec(i);
        capture(2000);
      join
      chk_frame($sformatf("v%0d", i), exp_seq, vecs[i].exp_n, vecs[i].exp_w1, vecs[i].exp_w2);
`ifdef FRAME_CHECKSUM_EN
      exp_x = 32'h0;
      for (int k = 0; k < vecs[i].exp_n; k++) exp_x = exp_x ^ vecs[i].nz[k];
      chk($sformatf("v%0d_trailer", i), cap_w[3], {32'h0, exp_x});
`endif
      wait_idle(100);
      chk($sformatf("v%0d_idle_to", i), idle_to, 1'b0);
      exp_seq = exp_seq + 16'd1;
      exp_ovf = exp_ovf | vecs[i].exp_ovf;
      chk($sformatf("v%0d_seq", i), frame_seq, exp_seq);
      chk($sformatf("v%0d_ovf", i), overflow, exp_ovf);
    end

    // Push-to-VSYNC latency and FIFO-full backpressure
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nonce_valid = 1'b1;
      nonce       = 32'h7000_0000 + 32'(k);
    end
    @(posedge clk);
    #1 nonce_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_e1_vsync", tx_vsync, 1'b0);
    chk("lat_full_ready", nonce_ready, 1'b0);
    chk("lat_e1_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    chk("lat_e2_vsync", tx_vsync, 1'b1);
    wait_idle(200);
    chk("lat_idle_to", idle_to, 1'b0);
    exp_seq = exp_seq + 16'd1;
    chk("lat_seq", frame_seq, exp_seq);

    // Reset asserted while line word 1 is on the bus
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nonce_valid = 1'b1;
      nonce       = 32'h8000_0000 + 32'(k);
    end
    @(negedge clk);
    nonce_valid = 1'b0;
    vcount = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (tx_valid) vcount++;
      if (vcount == 2) break;
    end
    chk("rl_word1_seen", vcount, 2);
    chk("rl_word1", tx_data, 64'h8000_0001_8000_0000);
    #1 rst = 1'b1;
    #1;
    chk("rl_vsync", tx_vsync, 1'b0);
    chk("rl_hsync", tx_hsync, 1'b0);
    chk("rl_valid", tx_valid, 1'b0);
    chk("rl_data", tx_data, 64'h0);
    chk("rl_busy", busy, 1'b0);
    chk("rl_ovf", overflow, 1'b0);
    chk("rl_seq", frame_seq, 16'h0);
    chk("rl_ready", nonce_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single nonce after reset: waits for the flush timer, FIFO held only this one
    vs_seen = 0;
    fork
      begin
        @(negedge clk);
        nonce_valid = 1'b1;
        nonce       = 32'hDEAD_BEEF;
        @(negedge clk);
        nonce_valid = 1'b0;
      end
      for (int cyc = 0; cyc < 1000; cyc++) begin
        @(negedge clk);
        if (tx_vsync) vs_seen++;
      end
    join
    chk("fl_no_early_vsync", vs_seen, 0);
    capture(500);
    chk_frame("fl", 16'h0, 1, 64'hFFFF_FFFF_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef FRAME_CHECKSUM_EN
    chk("fl_trailer", cap_w[3], 64'h0000_0000_DEAD_BEEF);
`endif
    wait_idle(100);
    chk("fl_idle_to", idle_to, 1'b0);
    chk("fl_seq", frame_seq, 16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nonce_tx_framer.md
Name: nonce_tx_framer

Overview:
Return path of the miner. Buffers golden nonces from the hash core and packs them into short MIPI CSI-2 TX frames, so the host sees results on the same link pair that delivers work. The block sits between the golden-nonce logic and the mipi_tx pixel interface, and drives VSYNC, HSYNC, VALID, DATA and TYPE directly.

Parameters:
FIFO_AW, 2, log2 of the nonce FIFO depth (4 entries).
NPL, 4, nonces per line; must be even and at least 2.
SYNC_CYC, 4, width of each VSYNC/HSYNC pulse in clocks.
GAP_CYC, 8, idle clocks between sync edges and the line.
FLUSH_CYC, 1024, IDLE wait before a partial frame is sent.

Ports:
tx_pixel_clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
nonce_valid  in  1  push strobe, single cycle, already in tx_pixel_clk domain
nonce  in  32  golden nonce
nonce_ready  out  1  FIFO not full
tx_vsync  out  1  to mipi_tx_VSYNC
tx_hsync  out  1  to mipi_tx_HSYNC
tx_valid  out  1  to mipi_tx_VALID
tx_data  out  64  to mipi_tx_DATA
tx_type  out  6  constant 6'h2A (RAW8)
tx_hres  out  16  pixels per line = 8*(1+NPL/2) (+8 with checksum)
busy  out  1  high outside IDLE
overflow  out  1  sticky; set when a nonce is dropped
frame_seq  out  16  frames sent, wraps

Behaviour:
Reset (async, active-high): all outputs 0 except nonce_ready=1 and tx_type/tx_hres at their constants. FIFO is emptied; seq, timers and overflow are cleared. Reset asserted mid-frame aborts the frame immediately; no trailing sync is emitted.

Push rules:
- nonce_valid with FIFO not full: nonce is written.
- nonce_valid with FIFO full and no pop that cycle: nonce is dropped and overflow is set.
- Push and pop in the same cycle while full: the push is accepted.

States and transitions:
- IDLE: the flush timer counts while the FIFO is non-empty. It moves to VS when occupancy ≥ NPL or the timer reaches FLUSH_CYC. On that entry, n = min(occupancy, NPL) is latched and the timer clears.
- VS: tx_vsync=1 for SYNC_CYC clocks.
- GAP1: GAP_CYC clocks.
- HS: tx_hsync=1 for SYNC_CYC clocks.
- GAP2: GAP_CYC clocks.
- LINE: tx_valid=1 for exactly 1+NPL/2 consecutive clocks.
  - Word 0 = {32'hA5C35A3C, frame_seq, 16'(n)}.
  - Word k = {nonce[2k-1], nonce[2k-2]}, lower nonce in bits 31:0.
  - Slots ≥ n are filled with 32'hFFFFFFFF.
  - A FIFO pop occurs per nonce slot < n.
- TRAIL: GAP_CYC clocks. frame_seq is incremented (mod 2^16) on exit, then the block returns to IDLE.

Outside LINE, tx_data=0. Nonces pushed during a frame are queued for the next frame. Latency from a push that makes occupancy = NPL to the first tx_vsync is 2 clocks (registered outputs).

Optional Feature:
FRAME_CHECKSUM_EN
- Defined: LINE carries one extra trailer word {32'h0, XOR of the n real nonces}, with padding excluded, and tx_hres grows by 8.
- Undefined: no trailer word; line length is 1+NPL/2.

Decomposition:
- Package nonce_tx_pkg holds:
  - MAGIC = 32'hA5C35A3C
  - TX_TYPE = 6'h2A
  - PAD_NONCE = 32'hFFFFFFFF
  - the state enum {IDLE, VS, GAP1, HS, GAP2, LINE, TRAIL}
  - a line-word count function of NPL and the macro.
- Sub-module nonce_fifo: synchronous FIFO, depth 2^FIFO_AW, 32 bits wide, with full/empty/count outputs. The framer FSM and packer stay in nonce_tx_framer.

Test Plan:
1. Push 4 nonces 0x11111111..0x44444444 on back-to-back clocks → one frame:
   - VSYNC 4 clocks, then HSYNC 4 clocks.
   - 3 valid words: {A5C35A3C,0000,0004}, {22222222,11111111}, {44444444,33333333}.
   - frame_seq goes 0 to 1.
2. Push single nonce 0xDEADBEEF → no VSYNC before 1024 idle clocks, then word0 count=1 and word1 {FFFFFFFF,DEADBEEF}.
3. Push 6 nonces with no gap while IDLE → the 5th is accepted (FIFO 4 deep, but popping has not started) only if a pop coincides; otherwise overflow=1 and exactly 4 nonces appear in frame 0.
4. Assert reset during LINE after word 1 → all outputs 0 in the same cycle; after release, FIFO is empty and frame_seq=0.
5. Run 65536 frames → frame_seq wraps 0xFFFF to 0x0000 and the header reflects it.
6. With FRAME_CHECKSUM_EN, push 0x0F0F0F0F and 0xF0F0F0F1, then wait for the flush → trailer word 0x00000000_FFFFFFFE and tx_hres=32.
